// File: rtl/oclib_pkg.sv
// Shared constants for the oclib blocks; beat-order selection uses True/False.
package oclib_pkg;
    localparam bit False = 1'b0;
    localparam bit True  = 1'b1;
endpackage

// File: rtl/oclib_ready_valid_serializer.sv
// Width-reducing ready/valid stage: one wide word in, up to Ratio narrow beats out
// with a last-beat marker. Final-beat handshake and next-word accept may coincide.
module oclib_ready_valid_serializer
    import oclib_pkg::*;
#(
    parameter int Width    = 8,
    parameter int Ratio    = 4,
    parameter bit MsbFirst = False,
    localparam int BeatsW  = $clog2(Ratio + 1),
    localparam int IdxW    = (Ratio > 1) ? $clog2(Ratio) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Width*Ratio-1:0]   inData,
    input  logic [BeatsW-1:0]        inBeats,
    input  logic                     inValid,
    output logic                     inReady,
    output logic [Width-1:0]         outData,
    output logic                     outValid,
    output logic                     outLast,
    input  logic                     outReady
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [IdxW-1:0] LastSlice = IdxW'(Ratio - 1);

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        beat_q, beat_d;
    logic [IdxW-1:0]        last_q, last_d;
    logic                   init_q;
    logic [Width*Ratio-1:0] hold_q;
    logic [IdxW-1:0]        last_in;
    logic [IdxW-1:0]        slice_idx;
    logic                   accept;
    logic [Width-1:0]       slices [Ratio];

    genvar gi;
    generate
        for (gi = 0; gi < Ratio; gi++) begin : g_slice
            assign slices[gi] = hold_q[gi*Width +: Width];
        end
    endgenerate

    // init_q keeps inReady low until the first clock after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            init_q  <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            hold_q <= inData;
        end
    end

    // Out-of-range beat counts (0 or above Ratio) mean a full word.
    always_comb begin
        last_in = LastSlice;
        if (inBeats != '0 && inBeats <= BeatsW'(Ratio)) begin
            last_in = IdxW'(inBeats - 1'b1);
        end
    end

    assign accept = inValid && inReady;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        if (accept) begin
            state_d = SEND;
            beat_d  = '0;
            last_d  = last_in;
        end else if (state_q == SEND && outReady) begin
            if (beat_q == last_q) begin
                state_d = IDLE;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        outValid  = (state_q == SEND);
        outLast   = outValid && (beat_q == last_q);
        slice_idx = MsbFirst ? (LastSlice - beat_q) : beat_q;
        outData   = slices[slice_idx];
        inReady   = init_q && (!outValid || (outReady && outLast));
    end

endmodule

// File: tb/tb_oclib_ready_valid_serializer.sv
// Bench for the serializer: LSB-first and MSB-first instances share stimulus and are
// compared each cycle against a beat-queue model, plus directed literal expectations.
module tb_oclib_ready_valid_serializer;
    import oclib_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inData;
    logic [2:0]  inBeats;
    logic        inValid;
    logic        outReady;
    logic        inReady_l, outValid_l, outLast_l;
    logic        inReady_m, outValid_m, outLast_m;
    logic [7:0]  outData_l, outData_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_rdy = 0;

    // Model: beats still owed for the word currently held.
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    bit         rdy_ok;

    oclib_ready_valid_serializer #(.Width(8), .Ratio(4), .MsbFirst(False)) dut_l (
        .clock(clock), .reset(reset), .inData(inData), .inBeats(inBeats),
        .inValid(inValid), .inReady(inReady_l), .outData(outData_l),
        .outValid(outValid_l), .outLast(outLast_l), .outReady(outReady));

    oclib_ready_valid_serializer #(.Width(8), .Ratio(4), .MsbFirst(True)) dut_m (
        .clock(clock), .reset(reset), .inData(inData), .inBeats(inBeats),
        .inValid(inValid), .inReady(inReady_m), .outData(outData_m),
        .outValid(outValid_m), .outLast(outLast_m), .outReady(outReady));

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return rdy_ok && (q_l.size() == 0 || (q_l.size() == 1 && outReady));
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_l.delete();
            q_m.delete();
            rdy_ok = 0;
        end else begin
            bit acc;
            int eff;
            logic [31:0] w;
            acc = inValid && model_ready();
            if (q_l.size() > 0 && outReady) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
            if (acc) begin
                eff = (inBeats == 0 || inBeats > 4) ? 4 : int'(inBeats);
                w = inData;
                for (int k = 0; k < eff; k++) begin
                    q_l.push_back(w[k*8 +: 8]);
                    q_m.push_back(w[(3-k)*8 +: 8]);
                end
            end
            rdy_ok = 1;
        end
    end

    always @(negedge clock) begin
        chk("inReady_lsb",  {31'b0, inReady_l},  {31'b0, model_ready()});
        chk("inReady_msb",  {31'b0, inReady_m},  {31'b0, model_ready()});
        chk("outValid_lsb", {31'b0, outValid_l}, {31'b0, q_l.size() > 0});
        chk("outValid_msb", {31'b0, outValid_m}, {31'b0, q_m.size() > 0});
        chk("outLast_lsb",  {31'b0, outLast_l},  {31'b0, q_l.size() == 1});
        chk("outLast_msb",  {31'b0, outLast_m},  {31'b0, q_m.size() == 1});
        if (q_l.size() > 0) begin
            chk("outData_lsb", {24'b0, outData_l}, {24'b0, q_l[0]});
            chk("outData_msb", {24'b0, outData_m}, {24'b0, q_m[0]});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_rdy) outReady = 1'($urandom_range(0, 1));
    endtask

    // Hold inValid until the word is taken, then scramble the inputs.
    task automatic send_word(input logic [31:0] data, input logic [2:0] beats, input bit drop);
        bit ok;
        int n;
        inValid = 1'b1;
        inData  = data;
        inBeats = beats;
        n = 0;
        forever begin
            @(negedge clock);
            ok = inReady_l;
            tick();
            if (ok) break;
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL accept_timeout: word %0h not accepted within 200 cycles", data);
                break;
            end
        end
        if (drop) inValid = 1'b0;
        inData  = $urandom;
        inBeats = 3'($urandom_range(0, 7));
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] l, input logic [7:0] m,
                               input bit last, input bit rdy);
        @(negedge clock);
        chk({tag, "_lsb"},  {24'b0, outData_l}, {24'b0, l});
        chk({tag, "_msb"},  {24'b0, outData_m}, {24'b0, m});
        chk({tag, "_last"}, {31'b0, outLast_l}, {31'b0, last});
        chk({tag, "_rdy"},  {31'b0, inReady_l}, {31'b0, rdy});
        tick();
    endtask

    initial begin
        int start;
        reset    = 1'b0;
        inData   = '0;
        inBeats  = '0;
        inValid  = 1'b0;
        outReady = 1'b1;

        @(negedge clock);
        chk("rst_outValid", {31'b0, outValid_l}, 32'd0);
        chk("rst_inReady",  {31'b0, inReady_l},  32'd0);
        chk("rst_outLast",  {31'b0, outLast_l},  32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Full word, LSB-first and MSB-first orders.
        send_word(32'h44332211, 3'd4, 1);
        expect_beat("full_b0", 8'h11, 8'h44, 0, 0);
        expect_beat("full_b1", 8'h22, 8'h33, 0, 0);
        expect_beat("full_b2", 8'h33, 8'h22, 0, 0);
        expect_beat("full_b3", 8'h44, 8'h11, 1, 1);
        $display("full word done at cycle %0d", cyc);

        // Partial word of two beats.
        send_word(32'h44332211, 3'd2, 1);
        expect_beat("part_b0", 8'h11, 8'h44, 0, 0);
        expect_beat("part_b1", 8'h22, 8'h33, 1, 1);
        @(negedge clock);
        chk("part_idle", {31'b0, outValid_l}, 32'd0);
        tick();
        $display("partial word done at cycle %0d", cyc);

        // inBeats=0 and inBeats=7 both mean four beats.
        send_word(32'hA0B0C0D0, 3'd0, 1);
        expect_beat("zero_b0", 8'hD0, 8'hA0, 0, 0);
        expect_beat("zero_b1", 8'hC0, 8'hB0, 0, 0);
        expect_beat("zero_b2", 8'hB0, 8'hC0, 0, 0);
        expect_beat("zero_b3", 8'hA0, 8'hD0, 1, 1);
        send_word(32'h01020304, 3'd7, 1);
        expect_beat("over_b0", 8'h04, 8'h01, 0, 0);
        expect_beat("over_b1", 8'h03, 8'h02, 0, 0);
        expect_beat("over_b2", 8'h02, 8'h03, 0, 0);
        expect_beat("over_b3", 8'h01, 8'h04, 1, 1);
        $display("out-of-range beat counts done at cycle %0d", cyc);

        // Back-to-back words: 8 beats in 8 cycles.
        send_word(32'h88776655, 3'd4, 0);
        start = cyc;
        send_word(32'hCCBBAA99, 3'd4, 1);
        chk("b2b_gap", 32'(cyc - start), 32'd4);
        expect_beat("b2b_b4", 8'h99, 8'hCC, 0, 0);
        expect_beat("b2b_b5", 8'hAA, 8'hBB, 0, 0);
        expect_beat("b2b_b6", 8'hBB, 8'hAA, 0, 0);
        expect_beat("b2b_b7", 8'hCC, 8'h99, 1, 1);
        chk("b2b_span", 32'(cyc - start), 32'd8);
        $display("back-to-back words done at cycle %0d", cyc);

        // Random backpressure, random beat counts.
        rand_rdy = 1;
        for (int i = 0; i < 30; i++) begin
            send_word($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end
        inValid = 1'b0;
        rand_rdy = 0;
        outReady = 1'b1;
        repeat (8) tick();
        $display("random backpressure done at cycle %0d", cyc);

        // Asynchronous reset in the middle of a word.
        send_word(32'h44332211, 3'd4, 1);
        expect_beat("prerst_b0", 8'h11, 8'h44, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_outValid", {31'b0, outValid_l}, 32'd0);
        chk("arst_outLast",  {31'b0, outLast_l},  32'd0);
        chk("arst_inReady",  {31'b0, inReady_l},  32'd0);
        tick(); tick();
        reset = 1'b1;
        @(negedge clock);
        chk("rel_inReady0", {31'b0, inReady_l}, 32'd0);
        tick();
        @(negedge clock);
        chk("rel_inReady1", {31'b0, inReady_l},  32'd1);
        chk("rel_outValid", {31'b0, outValid_l}, 32'd0);
        send_word(32'hDDCCBBAA, 3'd4, 1);
        expect_beat("post_b0", 8'hAA, 8'hDD, 0, 0);
        expect_beat("post_b1", 8'hBB, 8'hCC, 0, 0);
        expect_beat("post_b2", 8'hCC, 8'hBB, 0, 0);
        expect_beat("post_b3", 8'hDD, 8'hAA, 1, 1);
        $display("mid-word reset done at cycle %0d", cyc);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
